rr_handshake_arbiter: RTL



---
 rtl/rr_handshake_arbiter_if.sv | 27 ++
 rtl/rr_handshake_arbiter.sv | 114 +++++++++++
 2 files changed

// File: rtl/rr_handshake_arbiter_if.sv
// Bundle of the arbiter's downstream (req/ack/data) and upstream handshake signals.
// The master modport is the arbiter itself; the slave modport is its environment.
interface rr_handshake_arbiter_if #(
    parameter int num_req    = 4,
    parameter int data_width = 32,
    parameter int idx_width  = 2
);
    logic [num_req-1:0]    req_in;
    logic [num_req-1:0]    ack_out;
    logic [data_width-1:0] dout;
    logic                  up_req;
    logic                  up_ack;
    logic [data_width-1:0] up_din;
    logic [idx_width-1:0]  grant_idx;
    logic                  busy;
    logic [31:0]           grant_count;

    modport master (
        input  req_in, up_ack, up_din,
        output ack_out, dout, up_req, grant_idx, busy, grant_count
    );

    modport slave (
        output req_in, up_ack, up_din,
        input  ack_out, dout, up_req, grant_idx, busy, grant_count
    );
endinterface

// File: rtl/rr_handshake_arbiter.sv
// Round-robin arbiter sharing one upstream req/ack source among num_req requesters.
// One transaction at a time: IDLE arbitrates, REQ waits for up_ack, DONE is a dead cycle.
module rr_handshake_arbiter #(
    parameter int num_req    = 4,
    parameter int data_width = 32,
    parameter int idx_width  = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    rr_handshake_arbiter_if.master       io_bus
);

    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

    state_t                r_state, w_state_nxt;
    logic [num_req-1:0]    r_ack, w_ack_nxt;
    logic [data_width-1:0] r_dout, w_dout_nxt;
    logic                  r_up_req, w_up_req_nxt;
    logic                  r_busy, w_busy_nxt;
    logic [31:0]           r_count, w_count_nxt;
    logic [idx_width-1:0]  r_grant, w_grant_nxt;
    logic [idx_width-1:0]  r_last, w_last_nxt;

    int                    w_sh;
    int                    w_off;
    logic [num_req-1:0]    w_rot;
    logic [idx_width-1:0]  w_pick;
    logic                  w_any;

    // Rotate the request vector so the requester after r_last sits at bit 0,
    // then take the lowest set bit and map it back to an absolute index.
    always_comb begin
        w_sh  = (int'(r_last) + 1) % num_req;
        w_rot = num_req'({io_bus.req_in, io_bus.req_in} >> w_sh);
        w_off = 0;
        for (int j = num_req - 1; j >= 0; j--) begin
            if (((w_rot >> j) & num_req'(1)) != '0) begin
                w_off = j;
            end
        end
        w_pick = idx_width'((w_sh + w_off) % num_req);
        w_any  = |io_bus.req_in;
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_ack_nxt    = r_ack;
        w_dout_nxt   = r_dout;
        w_up_req_nxt = r_up_req;
        w_busy_nxt   = r_busy;
        w_count_nxt  = r_count;
        w_grant_nxt  = r_grant;
        w_last_nxt   = r_last;
        case (r_state)
            IDLE: begin
                if (w_any) begin
                    w_grant_nxt  = w_pick;
                    w_up_req_nxt = 1'b1;
                    w_busy_nxt   = 1'b1;
                    w_state_nxt  = REQ;
                end
            end
            REQ: begin
                // Grant is held even if the requester drops req before up_ack.
                if (io_bus.up_ack) begin
                    w_dout_nxt   = io_bus.up_din;
                    w_ack_nxt    = {{(num_req-1){1'b0}}, 1'b1} << r_grant;
                    w_up_req_nxt = 1'b0;
                    w_count_nxt  = r_count + 32'd1;
                    w_last_nxt   = r_grant;
                    w_state_nxt  = DONE;
                end
            end
            DONE: begin
                w_ack_nxt   = '0;
                w_busy_nxt  = 1'b0;
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_ack    <= '0;
            r_dout   <= '0;
            r_up_req <= 1'b0;
            r_busy   <= 1'b0;
            r_count  <= '0;
            r_grant  <= '0;
            r_last   <= idx_width'(num_req - 1);
        end else begin
            r_state  <= w_state_nxt;
            r_ack    <= w_ack_nxt;
            r_dout   <= w_dout_nxt;
            r_up_req <= w_up_req_nxt;
            r_busy   <= w_busy_nxt;
            r_count  <= w_count_nxt;
            r_grant  <= w_grant_nxt;
            r_last   <= w_last_nxt;
        end
    end

    assign io_bus.ack_out     = r_ack;
    assign io_bus.dout        = r_dout;
    assign io_bus.up_req      = r_up_req;
    assign io_bus.grant_idx   = r_grant;
    assign io_bus.busy        = r_busy;
    assign io_bus.grant_count = r_count;

endmodule
